// File: rtl/retire_tracer.sv
// retire_tracer: two-slot retire capture into a record FIFO, one registered trace record out per cycle.
// Define RETIRE_TRACER_SEQ_EN to add the seq output (count of valid records emitted before the current one).
module retire_tracer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        s0_v,
  input  logic        s0_rdv,
  input  logic        s0_pcv,
  input  logic [31:0] s0_pc,
  input  logic [31:0] s0_inst,
  input  logic [4:0]  s0_rd_x,
  input  logic [31:0] s0_rd_data,
  input  logic [31:0] s0_pc_x,
  input  logic        s1_v,
  input  logic        s1_rdv,
  input  logic        s1_pcv,
  input  logic [31:0] s1_pc,
  input  logic [31:0] s1_inst,
  input  logic [4:0]  s1_rd_x,
  input  logic [31:0] s1_rd_data,
  input  logic [31:0] s1_pc_x,
  output logic        in_ready,
  output logic        valid,
  output logic        rdv,
  output logic        pcv,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [4:0]  rd_x,
  output logic [31:0] rd_data,
  output logic [31:0] pc_x
`ifdef RETIRE_TRACER_SEQ_EN
  ,
  output logic [31:0] seq
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic        v;
    logic        rdv;
    logic        pcv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_x;
    logic [31:0] rd_data;
    logic [31:0] pc_x;
  } rec_t;
  rec_t          mem_q [DEPTH];
  rec_t          out_q, out_d, s0, s1, rec_a, w0;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          s0p, s1p, bypass, pop, load;
  logic [1:0]    na, nw;
  assign s0 = {s0_v, s0_rdv, s0_pcv, s0_pc, s0_inst, s0_rd_x, s0_rd_data, s0_pc_x};
  assign s1 = {s1_v, s1_rdv, s1_pcv, s1_pc, s1_inst, s1_rd_x, s1_rd_data, s1_pc_x};
  assign s0p = s0_v | s0_rdv | s0_pcv;
  assign s1p = s1_v | s1_rdv | s1_pcv;
  assign in_ready = !reset && !flush && (cnt_q <= (AW+1)'(DEPTH - 2));
  // With an empty FIFO the oldest accepted record skips the FIFO and goes straight to the output.
  always_comb begin
    na     = in_ready ? 2'(s0p) + 2'(s1p) : 2'd0;
    rec_a  = s0p ? s0 : s1;
    pop    = !flush && (cnt_q != '0);
    bypass = !flush && (cnt_q == '0) && (na != 2'd0);
    load   = pop || bypass;
    nw     = bypass ? na - 2'd1 : na;
    w0     = bypass ? s1 : rec_a;
    cnt_d  = flush ? '0 : cnt_q + (AW+1)'(nw) - (AW+1)'(pop);
    rd_d   = flush ? '0 : rd_q + AW'(pop);
    wr_d   = flush ? '0 : wr_q + AW'(nw);
    out_d  = load ? (pop ? mem_q[rd_q] : rec_a) : {3'b000, out_q[132:0]};
  end
  always_ff @(posedge clk) begin
    if (nw != 2'd0) mem_q[wr_q] <= w0;
    if (nw == 2'd2) mem_q[AW'(wr_q + 1'b1)] <= s1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  assign {valid, rdv, pcv, pc, inst, rd_x, rd_data, pc_x} = out_q;
`ifdef RETIRE_TRACER_SEQ_EN
  logic [31:0] seq_q, vcnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q  <= '0;
      vcnt_q <= '0;
    end else if (load) begin
      seq_q  <= vcnt_q;
      vcnt_q <= vcnt_q + 32'(out_d.v);
    end
  end
  assign seq = seq_q;
`endif
endmodule

// File: doc/retire_tracer.md
RETIRE_TRACER -- requirements
Module: retire_tracer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, record FIFO entries (power of two, >= 4).
REQ-002 SHALL have ports clk  input  1  sole clock, rising edge.
REQ-003 SHALL have ports reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports flush  input  1  synchronous discard of all queued records.
REQ-005 SHALL have ports s0_v, s0_rdv, s0_pcv  input  1 each  slot-0 instruction-retire, writeback and PC-update flags.
REQ-006 SHALL have ports s0_pc, s0_inst, s0_rd_data, s0_pc_x  input  32 each, and s0_rd_x  input  5  slot-0 fields.
REQ-007 SHALL have ports s1_v, s1_rdv, s1_pcv, s1_pc, s1_inst, s1_rd_x, s1_rd_data, s1_pc_x  input  same widths  slot-1 fields, younger than slot 0.
REQ-008 SHALL have ports in_ready  output  1  both slots may be accepted this cycle.
REQ-009 SHALL have ports valid, rdv, pcv  output  1 each, and pc, inst, rd_data, pc_x  output  32 each, and rd_x  output  5  trace record to the trace monitor.

Function
REQ-010 A slot SHALL be present when any of its v, rdv or pcv is 1; an absent slot carries no record.
REQ-011 Slots SHALL be accepted only in a cycle with in_ready=1 and flush=0; presented slots are ignored otherwise.
REQ-012 in_ready SHALL be 1 exactly when at least 2 FIFO entries are free and flush=0, computed from registered count only.
REQ-013 Accepted records SHALL be enqueued in order slot 0 then slot 1; a lone present slot 1 SHALL occupy slot 0's position, with no gap entry.
REQ-014 The output SHALL be registered; each rising edge loads the FIFO head into the outputs and pops it, at most one record per cycle.
REQ-015 Latency SHALL be exactly 1 cycle from acceptance to output when the FIFO is empty (bypass into the output register); there SHALL be no bubble between back-to-back records.
REQ-016 When no record is available, valid, rdv and pcv SHALL be 0, and the data outputs SHALL hold their last values.
REQ-017 The record fields (v->valid, rdv, pcv, pc, inst, rd_x, rd_data, pc_x) SHALL be passed unmodified; records with valid=0 and rdv or pcv=1 SHALL be emitted as-is.
REQ-018 Count SHALL update in the same cycle as simultaneous push(0..2) and pop(0..1) without loss; read and write pointers SHALL wrap modulo DEPTH.
REQ-019 flush=1 SHALL empty the FIFO and force valid, rdv and pcv to 0 on the next edge; flush SHALL override any same-cycle push or pop.
REQ-020 The FIFO SHALL never overflow; pushing when full is unreachable by REQ-012.

Reset
REQ-021 While reset=1, pointers and count SHALL be 0, valid, rdv and pcv SHALL be 0, all data outputs SHALL be 0, and in_ready SHALL be 0.
REQ-022 Assertion of reset mid-stream SHALL discard all queued records immediately, without waiting for a clock edge.
REQ-023 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-024 Macro RETIRE_TRACER_SEQ_EN defined: the module SHALL add output seq (32 bits), set to the count of valid=1 records emitted before the current one. seq SHALL reset to 0, wrap at 2^32 and be unaffected by flush.
REQ-025 Macro RETIRE_TRACER_SEQ_EN undefined: the seq port and its counter SHALL be absent, with the module otherwise identical.

Verification
REQ-026 Reset release, then single slot-0 record v=1, pc=0x0000_0100, inst=0x0010_0093, rdv=1, rd_x=1, rd_data=1 -> the next cycle shows the same values with valid=1, and the cycle after shows valid=0.
REQ-027 Both slots present on each of 4 consecutive cycles with DEPTH=8 -> in_ready drops to 0 once free < 2; 8 records emerge in order on consecutive cycles with pc ascending by 4; none are lost.
REQ-028 Slot 1 only: v=0, rdv=0, pcv=1, pc_x=0x0000_0200 -> one output record with valid=0, pcv=1, pc_x=0x0000_0200, and no empty record before it.
REQ-029 flush asserted while 5 records are queued, with a same-cycle push -> the next edge shows valid=rdv=pcv=0 and count=0; the pushed slots never appear.
REQ-030 reset pulsed asynchronously between edges with 3 queued records -> outputs are 0 immediately; after release in_ready=1 and no stale record appears.
REQ-031 With RETIRE_TRACER_SEQ_EN, 3 valid records, then a rdv-only record, then a valid record -> seq reads 0,1,2, then 3 on the rdv-only record, then 3 again.
